// File: rtl/amdc_timing_pkg.sv
// Shared types and encodings for the AMDC timing/trigger core.
package amdc_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TRIG,
    ST_ACQ,
    ST_DONE
  } state_e;

  localparam logic       MODE_PWM   = 1'b0;
  localparam logic       MODE_TIMER = 1'b1;

  localparam logic [1:0] EVSEL_NONE = 2'b00;
  localparam logic [1:0] EVSEL_HIGH = 2'b01;
  localparam logic [1:0] EVSEL_LOW  = 2'b10;
  localparam logic [1:0] EVSEL_BOTH = 2'b11;

  function automatic logic is_busy(state_e s);
    return (s == ST_TRIG) || (s == ST_ACQ) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/amdc_timing_event_src.sv
// Event source: PWM/timer mux, period timer and ratio decimator.
// trigger_due is combinational in the cycle of the completing event.
module amdc_timing_event_src
  import amdc_timing_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int RATIO_W = 8
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               en,
  input  logic               mode,
  input  logic               carrier_high,
  input  logic               carrier_low,
  input  logic [1:0]         event_sel,
  input  logic [CNT_W-1:0]   timer_period,
  input  logic [RATIO_W-1:0] ratio,
  output logic               trigger_due
);

  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [RATIO_W-1:0] ev_q, ev_d;
  logic [RATIO_W-1:0] ratio_eff;
  logic [RATIO_W:0]   ev_inc;
  logic               wrap, qual;

  always_comb begin
    ratio_eff = (ratio == '0) ? {{(RATIO_W-1){1'b0}}, 1'b1} : ratio;
    // >= so a live period reduction below the running count still wraps
    wrap      = (tmr_q >= timer_period);
    tmr_d     = (!en || wrap) ? '0 : tmr_q + 1'b1;
    qual      = en && ((mode == MODE_TIMER) ? wrap :
                       ((carrier_high && event_sel[0]) || (carrier_low && event_sel[1])));
    ev_inc      = {1'b0, ev_q} + 1'b1;
    trigger_due = qual && (ev_inc >= {1'b0, ratio_eff});
    ev_d = ev_q;
    if (!en || trigger_due) ev_d = '0;
    else if (qual)          ev_d = ev_inc[RATIO_W-1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tmr_q <= '0;
      ev_q  <= '0;
    end else begin
      tmr_q <= tmr_d;
      ev_q  <= ev_d;
    end
  end

endmodule

// File: rtl/amdc_timing_trigger_core.sv
// N-channel acquisition trigger scheduler: fires channel triggers on a
// decimated event, times each channel until done, then raises an interrupt.
module amdc_timing_trigger_core
  import amdc_timing_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int CNT_W   = 16,
  parameter int RATIO_W = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  carrier_high,
  input  logic                  carrier_low,
  input  logic [1:0]            event_sel,
  input  logic [CNT_W-1:0]      timer_period,
  input  logic [RATIO_W-1:0]    ratio,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       ch_done,
  input  logic                  overrun_clr,
  output logic [N_CH-1:0]       ch_trigger,
  output logic [N_CH*CNT_W-1:0] ch_time,
  output logic                  sched_irq,
  output logic                  busy,
  output logic                  overrun
);

  state_e          state_q, state_d;
  logic [N_CH-1:0] pend_q, pend_d, trig_q, trig_d, acc;
  logic            busy_q, busy_d, irq_q, irq_d, ovr_q, ovr_d;
  logic            due, start;

  amdc_timing_event_src #(.CNT_W(CNT_W), .RATIO_W(RATIO_W)) u_src (
    .ACLK(ACLK), .ARESETN(ARESETN), .en(en), .mode(mode),
    .carrier_high(carrier_high), .carrier_low(carrier_low),
    .event_sel(event_sel), .timer_period(timer_period), .ratio(ratio),
    .trigger_due(due)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    acc     = (en && state_q == ST_ACQ) ? (pend_q & ch_done) : '0;
    start   = en && (state_q == ST_WAIT) && due;
    ovr_d   = overrun_clr ? 1'b0 : ovr_q;
    if (due && is_busy(state_q)) ovr_d = 1'b1;
    if (!en) begin
      state_d = ST_IDLE;
      pend_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT;
        ST_WAIT: if (due) begin
          state_d = ST_TRIG;
          pend_d  = ch_en;
        end
        ST_TRIG: state_d = ST_ACQ;
        ST_ACQ: begin
          pend_d = pend_q & ~acc;
          if (pend_d == '0) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_WAIT;
        default: state_d = ST_IDLE;
      endcase
    end
    trig_d = (state_d == ST_TRIG) ? pend_d : '0;
    busy_d = is_busy(state_d);
    irq_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      trig_q  <= '0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ch_trigger = trig_q;
  assign busy       = busy_q;
  assign sched_irq  = irq_q;
  assign overrun    = ovr_q;

  // Counter is 0 in TRIG, so a done k cycles after TRIG captures k.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, time_q, time_d;

    always_comb begin
      cnt_d = cnt_q;
      if (start && ch_en[i])
        cnt_d = '0;
      else if (en && pend_q[i] && (state_q == ST_TRIG || state_q == ST_ACQ) && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
      time_d = acc[i] ? cnt_q : time_q;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        cnt_q  <= '0;
        time_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        time_q <= time_d;
      end
    end

    assign ch_time[i*CNT_W +: CNT_W] = time_q;
  end

endmodule

// File: tb/tb_amdc_timing_trigger_core.sv
// Bench: cycle-level reference model from the timing rules, compared every
// cycle against a 16-bit and a 4-bit counter instance, plus directed scenarios.
module tb_amdc_timing_trigger_core;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic        en = 1'b0, mode = 1'b0, carrier_high = 1'b0, carrier_low = 1'b0;
  logic [1:0]  event_sel = 2'b00;
  logic [15:0] timer_period = '0;
  logic [7:0]  ratio = '0, ch_en = '0, ch_done = '0;
  logic        overrun_clr = 1'b0;

  logic [7:0]   ch_trigger, ch_trigger4;
  logic [127:0] ch_time;
  logic [31:0]  ch_time4;
  logic         sched_irq, busy, overrun, sched_irq4, busy4, overrun4;

  always #5 ACLK = ~ACLK;

  amdc_timing_trigger_core #(.N_CH(8), .CNT_W(16), .RATIO_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .en(en), .mode(mode),
    .carrier_high(carrier_high), .carrier_low(carrier_low), .event_sel(event_sel),
    .timer_period(timer_period), .ratio(ratio), .ch_en(ch_en), .ch_done(ch_done),
    .overrun_clr(overrun_clr), .ch_trigger(ch_trigger), .ch_time(ch_time),
    .sched_irq(sched_irq), .busy(busy), .overrun(overrun));

  amdc_timing_trigger_core #(.N_CH(8), .CNT_W(4), .RATIO_W(8)) dut4 (
    .ACLK(ACLK), .ARESETN(ARESETN), .en(en), .mode(mode),
    .carrier_high(carrier_high), .carrier_low(carrier_low), .event_sel(event_sel),
    .timer_period(timer_period[3:0]), .ratio(ratio), .ch_en(ch_en), .ch_done(ch_done),
    .overrun_clr(overrun_clr), .ch_trigger(ch_trigger4), .ch_time(ch_time4),
    .sched_irq(sched_irq4), .busy(busy4), .overrun(overrun4));

  int n_cmp = 0, n_fail = 0, cyc = 0;

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an acquisition window opens the cycle after an accepted
  // due event (trigger cycle T); a done in cycle c > T records c - T.
  bit       m_armed, m_active, m_ovr;
  int       m_T, m_irq_at, m_run, m_ev;
  bit [7:0] m_pend, m_mask;
  int       m_time[8];
  bit [7:0] e_trig;
  bit       e_busy, e_irq;

  always @(posedge ACLK or negedge ARESETN) begin
    bit qual, due;
    int ratio_eff;
    if (!ARESETN) begin
      m_armed = 0; m_active = 0; m_ovr = 0; m_T = 0; m_irq_at = -1;
      m_run = 0; m_ev = 0; m_pend = 0; m_mask = 0;
      for (int i = 0; i < 8; i++) m_time[i] = 0;
      e_trig = 0; e_busy = 0; e_irq = 0;
    end else begin
      cyc++;
      due = 0;
      ratio_eff = (ratio == 0) ? 1 : int'(ratio);
      if (en) begin
        if (mode) qual = ((m_run % (int'(timer_period) + 1)) == int'(timer_period));
        else      qual = (carrier_high && event_sel[0]) || (carrier_low && event_sel[1]);
        if (qual) begin
          if (m_ev + 1 >= ratio_eff) begin due = 1; m_ev = 0; end
          else m_ev++;
        end
        m_run++;
      end else begin
        m_ev = 0; m_run = 0;
      end
      if (overrun_clr) m_ovr = 0;
      if (due && m_active) m_ovr = 1;
      if (!en) m_active = 0;
      else if (m_active) begin
        if (m_irq_at == cyc) m_active = 0;
        else if (cyc > m_T) begin
          for (int i = 0; i < 8; i++)
            if (m_pend[i] && ch_done[i]) begin m_time[i] = cyc - m_T; m_pend[i] = 0; end
          if (m_pend == 0) m_irq_at = cyc + 1;
        end
      end else if (m_armed && due) begin
        m_active = 1; m_T = cyc + 1; m_pend = ch_en; m_mask = ch_en; m_irq_at = -1;
      end
      m_armed = en;
      e_trig = (m_active && m_T == cyc + 1) ? m_mask : 8'h00;
      e_busy = m_active;
      e_irq  = m_active && (m_irq_at == cyc + 1);
    end
  end

  always @(negedge ACLK) begin
    chk("ch_trigger", ch_trigger, e_trig);
    chk("busy", busy, e_busy);
    chk("sched_irq", sched_irq, e_irq);
    chk("overrun", overrun, m_ovr);
    chk("ch_trigger_w4", ch_trigger4, e_trig);
    chk("busy_w4", busy4, e_busy);
    chk("sched_irq_w4", sched_irq4, e_irq);
    chk("overrun_w4", overrun4, m_ovr);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ch_time[%0d]", i), ch_time[i*16 +: 16], longint'(m_time[i]));
      chk($sformatf("ch_time_w4[%0d]", i), ch_time4[i*4 +: 4],
          longint'((m_time[i] > 15) ? 15 : m_time[i]));
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(negedge ACLK); #1; end
  endtask

  task automatic pulse_high();
    carrier_high = 1'b1; step(); carrier_high = 1'b0;
  endtask

  initial begin
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_time", ch_time, 0);
    ARESETN = 1'b1; step(2);

    // PWM high events, ratio 3: only the third pulse triggers.
    mode = 1'b0; event_sel = 2'b01; ratio = 8'd3; ch_en = 8'h05; en = 1'b1; step(5);
    for (int p = 0; p < 3; p++) begin
      pulse_high();
      if (p < 2) begin chk("s1_no_trig", ch_trigger, 0); step(99); end
      else chk("s1_trig", ch_trigger, 8'h05);
    end
    step(7); ch_done = 8'h01; step(); ch_done = 8'h00;
    chk("s2_time0", ch_time[15:0], 7);
    step(12); ch_done = 8'h04; step(); ch_done = 8'h00;
    chk("s2_irq", sched_irq, 1);
    chk("s2_time2", ch_time[47:32], 20);
    chk("s2_busy_at_irq", busy, 1);
    step();
    chk("s2_busy_end", busy, 0);

    // Timer mode, period 9: triggers 10 cycles apart; second one overruns.
    en = 1'b0; step(2);
    mode = 1'b1; timer_period = 16'd9; ratio = 8'd0; ch_en = 8'h01; en = 1'b1;
    step(10);
    chk("s3_trig1", ch_trigger, 8'h01);
    step(10);
    chk("s3_ovr_set", overrun, 1);
    chk("s3_no_trig2", ch_trigger, 0);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("s3_ovr_clr", overrun, 0);
    ch_done = 8'h01; step(); ch_done = 8'h00;
    en = 1'b0; step(2);

    // No channels enabled: interrupt 3 cycles after the event.
    mode = 1'b0; event_sel = 2'b11; ratio = 8'd1; ch_en = 8'h00; en = 1'b1; step(3);
    carrier_low = 1'b1; step(); carrier_low = 1'b0;
    chk("s4_no_trig", ch_trigger, 0);
    ch_done = 8'h02; step(); ch_done = 8'h00;
    step();
    chk("s4_irq", sched_irq, 1);
    chk("s4_time1", ch_time[31:16], 0);
    step(3);

    // Saturation on the 4-bit instance.
    ch_en = 8'h01; event_sel = 2'b01;
    pulse_high();
    step(30); ch_done = 8'h01; step(); ch_done = 8'h00;
    chk("s5_sat_w4", ch_time4[3:0], 15);
    chk("s5_time_w16", ch_time[15:0], 30);
    step(3);

    // en dropped mid-acquisition, then reset mid-acquisition.
    ch_en = 8'h03;
    pulse_high(); step(5);
    en = 1'b0; step();
    chk("s6_en_busy", busy, 0);
    chk("s6_en_time0", ch_time[15:0], 30);
    step(3);
    en = 1'b1; step(3);
    pulse_high(); step(4);
    chk("s6_busy_before_rst", busy, 1);
    ARESETN = 1'b0; #2;
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_time", ch_time, 0);
    step(2); ARESETN = 1'b1; step(2);

    // Randomized configuration blocks.
    for (int blk = 0; blk < 40; blk++) begin
      en = 1'b0; step(2);
      mode = 1'($urandom_range(0, 1));
      event_sel = 2'($urandom_range(0, 3));
      ratio = 8'($urandom_range(0, 3));
      timer_period = 16'($urandom_range(0, 7));
      en = 1'b1;
      for (int c = 0; c < 100; c++) begin
        carrier_high = ($urandom_range(0, 5) == 0);
        carrier_low  = ($urandom_range(0, 5) == 0);
        ch_en        = 8'($urandom);
        ch_done      = 8'($urandom & $urandom & $urandom);
        overrun_clr  = ($urandom_range(0, 9) == 0);
        en           = ($urandom_range(0, 96) != 0);
        step();
      end
    end
    en = 1'b0; ch_done = '0; carrier_high = 1'b0; carrier_low = 1'b0; overrun_clr = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
